// File: rtl/motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : motion_sequencer
// Description : Tick-paced two-motor command sequencer with speed ramps.
// Revision    : 1.0 - initial release
// ============================================================================

module motion_sequencer #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter logic [15:0] SPEED_MAX = 16'd50000,
  parameter logic [15:0] RAMP_STEP = 16'd5000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_dur,
  input  logic        abort,
  output logic [15:0] speed_left,
  output logic [15:0] speed_right,
  output logic        motor_en_left,
  output logic        motor_en_right,
  output logic        busy,
  output logic        done
);

  localparam int unsigned        C_CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TICK_DIV - 1);
  localparam logic [1:0]         C_OP_STOP  = 2'b00;
  localparam logic [1:0]         C_OP_FWD   = 2'b01;
  localparam logic [1:0]         C_OP_LEFT  = 2'b10;
  localparam logic [1:0]         C_OP_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RUN       = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t             r_state;
  logic [C_CNT_W-1:0] r_count;
  logic [15:0]        r_speed_l;
  logic [15:0]        r_speed_r;
  logic [15:0]        r_tgt_l;
  logic [15:0]        r_tgt_r;
  logic [7:0]         r_dur;
  logic               r_done;

  logic               w_tick;
  logic               w_accept;
  logic [15:0]        w_new_tgt_l;
  logic [15:0]        w_new_tgt_r;
  logic [15:0]        w_up_l;
  logic [15:0]        w_up_r;
  logic [15:0]        w_dn_l;
  logic [15:0]        w_dn_r;

  // One ramp step toward tgt; 17-bit arithmetic so neither direction wraps.
  function automatic logic [15:0] f_step_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt);
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    w_sum  = {1'b0, cur} + {1'b0, RAMP_STEP};
    w_diff = {1'b0, cur} - {1'b0, RAMP_STEP};
    if (cur < tgt)
      return (w_sum > {1'b0, tgt}) ? tgt : w_sum[15:0];
    else if (cur > tgt)
      return (w_diff[16] || (w_diff[15:0] < tgt)) ? tgt : w_diff[15:0];
    else
      return cur;
  endfunction

  assign w_tick      = (r_count == C_CNT_LAST);
  assign cmd_ready   = n_rst && (r_state == S_IDLE) && !abort;
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_new_tgt_l = ((cmd_op == C_OP_FWD) || (cmd_op == C_OP_RIGHT)) ? SPEED_MAX : 16'd0;
  assign w_new_tgt_r = ((cmd_op == C_OP_FWD) || (cmd_op == C_OP_LEFT))  ? SPEED_MAX : 16'd0;
  assign w_up_l      = f_step_toward(r_speed_l, r_tgt_l);
  assign w_up_r      = f_step_toward(r_speed_r, r_tgt_r);
  assign w_dn_l      = f_step_toward(r_speed_l, 16'd0);
  assign w_dn_r      = f_step_toward(r_speed_r, 16'd0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_speed_l <= 16'd0;
      r_speed_r <= 16'd0;
      r_tgt_l   <= 16'd0;
      r_tgt_r   <= 16'd0;
      r_dur     <= 8'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state   <= S_IDLE;
        r_speed_l <= 16'd0;
        r_speed_r <= 16'd0;
        r_dur     <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_tgt_l <= w_new_tgt_l;
              r_tgt_r <= w_new_tgt_r;
              r_dur   <= cmd_dur;
              if ((cmd_op == C_OP_STOP) || (cmd_dur == 8'd0))
                r_done <= 1'b1;
              else
                r_state <= S_RAMP_UP;
            end
          end
          S_RAMP_UP: begin
            if ((r_speed_l == r_tgt_l) && (r_speed_r == r_tgt_r)) begin
              r_state <= S_RUN;
            end else if (w_tick) begin
              r_speed_l <= w_up_l;
              r_speed_r <= w_up_r;
            end
          end
          S_RUN: begin
            if (w_tick) begin
              if (r_dur <= 8'd1) begin
                r_dur   <= 8'd0;
                r_state <= S_RAMP_DOWN;
              end else begin
                r_dur <= r_dur - 8'd1;
              end
            end
          end
          S_RAMP_DOWN: begin
            if ((r_speed_l == 16'd0) && (r_speed_r == 16'd0)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else if (w_tick) begin
              r_speed_l <= w_dn_l;
              r_speed_r <= w_dn_r;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign speed_left     = r_speed_l;
  assign speed_right    = r_speed_r;
  assign busy           = (r_state != S_IDLE);
  assign motor_en_left  = busy;
  assign motor_en_right = busy;
  assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_motion_sequencer
// Description : Directed vector bench for motion_sequencer (TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_motion_sequencer;

  localparam int unsigned TICK_DIV  = 4;
  localparam logic [15:0] SPEED_MAX = 16'd100;
  localparam logic [15:0] RAMP_STEP = 16'd30;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_dur = 8'd0;
  logic        abort = 1'b0;
  logic        cmd_ready;
  logic [15:0] speed_left;
  logic [15:0] speed_right;
  logic        motor_en_left;
  logic        motor_en_right;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  motion_sequencer #(
    .TICK_DIV (TICK_DIV),
    .SPEED_MAX(SPEED_MAX),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_dur       (cmd_dur),
    .abort         (abort),
    .speed_left    (speed_left),
    .speed_right   (speed_right),
    .motor_en_left (motor_en_left),
    .motor_en_right(motor_en_right),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [7:0]       dur;
    logic             exp_busy;
    int               n_chg;
    logic [7:0][15:0] exp_l;
    logic [7:0][15:0] exp_r;
    int               run_gap;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] dur);
    int w;
    @(negedge clk);
    cmd_op    = op;
    cmd_dur   = dur;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 32'(w < 50), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] pl, pr;
    logic [15:0] cl[8];
    logic [15:0] cr[8];
    int          ct[8];
    int          nch, done_cnt, done_at, en_bad, rdy_bad, busy_seen, bad_int;
    v = vecs[idx];
    nch = 0; done_cnt = 0; done_at = -1; en_bad = 0; rdy_bad = 0; busy_seen = 0; bad_int = 0;
    pl = 16'd0; pr = 16'd0;
    send_cmd(v.op, v.dur);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (speed_left !== pl || speed_right !== pr) begin
        if (nch < 8) begin
          cl[nch] = speed_left; cr[nch] = speed_right; ct[nch] = t;
        end
        nch++;
        pl = speed_left; pr = speed_right;
      end
      if (busy) busy_seen = 1;
      if (motor_en_left !== busy || motor_en_right !== busy) en_bad++;
      if (busy && cmd_ready) rdy_bad++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
      if (done_at >= 0 && t >= done_at + 3) break;
    end
    chk($sformatf("v%0d_done_count", idx), done_cnt, 1);
    chk($sformatf("v%0d_busy_seen", idx), busy_seen, 32'(v.exp_busy));
    chk($sformatf("v%0d_n_changes", idx), nch, v.n_chg);
    for (int k = 0; k < 8; k++) begin
      if (k < v.n_chg && k < nch) begin
        chk($sformatf("v%0d_left_step%0d", idx, k), cl[k], v.exp_l[k]);
        chk($sformatf("v%0d_right_step%0d", idx, k), cr[k], v.exp_r[k]);
      end
    end
    if (v.n_chg == 0) begin
      chk($sformatf("v%0d_done_latency", idx), done_at, 0);
    end else if (nch >= 8) begin
      chk($sformatf("v%0d_done_latency", idx), done_at, ct[7] + 1);
      chk($sformatf("v%0d_run_gap", idx), ct[4] - ct[3], v.run_gap);
      for (int k = 1; k < 8; k++)
        if (k != 4 && (ct[k] - ct[k-1]) != TICK_DIV) bad_int++;
      chk($sformatf("v%0d_ramp_interval", idx), bad_int, 0);
    end
    chk($sformatf("v%0d_enable_track", idx), en_bad, 0);
    chk($sformatf("v%0d_ready_while_busy", idx), rdy_bad, 0);
    chk($sformatf("v%0d_idle_after", idx),
        {busy, motor_en_left, motor_en_right, speed_left, speed_right}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][15:0] ramp;
    logic [7:0][15:0] flat;
    int               w;
    int               bad;
    logic [15:0]      max_l;
    ramp = {16'd0, 16'd10, 16'd40, 16'd70, 16'd100, 16'd90, 16'd60, 16'd30};
    flat = '0;
    vecs[0] = '{2'b01, 8'd3, 1'b1, 8, ramp, ramp, 16};
    vecs[1] = '{2'b10, 8'd2, 1'b1, 8, flat, ramp, 12};
    vecs[2] = '{2'b11, 8'd1, 1'b1, 8, ramp, flat, 8};
    vecs[3] = '{2'b00, 8'd5, 1'b0, 0, flat, flat, 0};
    vecs[4] = '{2'b01, 8'd0, 1'b0, 0, flat, flat, 0};

    // Reset state, with a command offered that must not be taken
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dur = 8'd3;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {cmd_ready, busy, done, motor_en_left, motor_en_right, speed_left, speed_right}, 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Abort while running at full speed
    send_cmd(2'b01, 8'd20);
    w = 0;
    while (speed_left !== 16'd100 && w < 100) begin @(negedge clk); w++; end
    chk("abort_reach_full", 32'(speed_left), 32'd100);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_outputs",
        {cmd_ready, busy, done, motor_en_left, motor_en_right, speed_left, speed_right}, 32'd0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abort_held", bad, 0);
    abort = 1'b0;
    #1 chk("ready_after_abort", 32'(cmd_ready), 32'd1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("no_done_after_abort", bad, 0);

    // Second command held during the first: ignored until done, then taken
    send_cmd(2'b01, 8'd1);
    cmd_op = 2'b10; cmd_dur = 8'd1; cmd_valid = 1'b1;
    max_l = 16'd0; bad = 0; w = 0;
    while (w < 200) begin
      @(negedge clk);
      w++;
      if (speed_left > max_l) max_l = speed_left;
      if (busy && cmd_ready) bad++;
      if (done) break;
    end
    chk("hold_first_done", 32'(done), 32'd1);
    chk("hold_first_was_fwd", 32'(max_l), 32'd100);
    chk("hold_ready_busy", bad, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_second_busy", 32'(busy), 32'd1);
    w = 0;
    while (speed_right !== 16'd30 && w < 50) begin @(negedge clk); w++; end
    chk("hold_second_left", {speed_left, speed_right}, {16'd0, 16'd30});
    w = 0;
    while (!done && w < 200) begin @(negedge clk); w++; end
    chk("hold_second_done", 32'(done), 32'd1);

    // Asynchronous reset during ramp-down, then a normal command
    send_cmd(2'b01, 8'd1);
    w = 0;
    while (speed_left !== 16'd70 && w < 200) begin @(negedge clk); w++; end
    chk("rst_reach_rampdown", 32'(speed_left), 32'd70);
    #2 n_rst = 1'b0;
    #1 chk("async_reset_outputs",
           {cmd_ready, busy, done, motor_en_left, motor_en_right, speed_left, speed_right}, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per sequencing tick (1 ms at 50 MHz).
REQ-002 Parameter SPEED_MAX, default 16'd50000, full-speed duty threshold for the PWM stage.
REQ-003 Parameter RAMP_STEP, default 16'd5000, per-tick speed change during ramps.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command can be accepted this cycle.
REQ-008 cmd_op  input  2  opcode: 00 STOP, 01 FWD, 10 LEFT, 11 RIGHT.
REQ-009 cmd_dur  input  8  run duration in ticks.
REQ-010 abort  input  1  emergency stop (obstacle), level-sensitive.
REQ-011 speed_left, speed_right  output  16 each  duty thresholds to the PWM stage.
REQ-012 motor_en_left, motor_en_right  output  1 each  motor driver enables.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse on normal command completion.

Function
REQ-015 The block SHALL contain a free-running prescaler counting 0..TICK_DIV-1; tick asserts for one cycle when count = TICK_DIV-1, then count wraps to 0.
REQ-016 The FSM SHALL have states IDLE, RAMP_UP, RUN, RAMP_DOWN.
REQ-017 cmd_ready SHALL be 1 only in IDLE with abort low; a command is accepted on cmd_valid & cmd_ready.
REQ-018 On acceptance, targets SHALL latch: FWD L=R=SPEED_MAX; LEFT L=0, R=SPEED_MAX; RIGHT L=SPEED_MAX, R=0; duration counter := cmd_dur.
REQ-019 Accepted STOP, or any op with cmd_dur = 0, SHALL stay IDLE and pulse done in the next cycle.
REQ-020 Otherwise the FSM SHALL enter RAMP_UP on the next edge.
REQ-021 RAMP_UP: on each tick, each speed moves toward its target by RAMP_STEP, clamped to the target (no overshoot); when both speeds equal their targets, the next edge enters RUN.
REQ-022 Ramp ticks SHALL NOT decrement the duration counter.
REQ-023 RUN: each tick decrements the duration counter; the tick at which it equals 1 moves to RAMP_DOWN.
REQ-024 RAMP_DOWN: each tick decreases each speed by RAMP_STEP, clamped at 0; when both are 0, the next edge enters IDLE and done pulses that cycle.
REQ-025 Saturating add/subtract SHALL be computed in 17 bits, with no wrap-around.
REQ-026 motor_en_left/right SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-027 abort high in any state SHALL, at the next edge, set both speeds to 0, go to IDLE, and clear the duration counter; done SHALL NOT pulse.
REQ-028 A cmd_valid arriving while busy SHALL be ignored (not queued); the requester holds it until cmd_ready.
REQ-029 The prescaler is not reset by commands, so the first tick latency after acceptance is 1..TICK_DIV cycles.

Reset
REQ-030 While n_rst is low, the block SHALL hold state IDLE, prescaler 0, speeds 0, duration 0, enables 0, done 0, busy 0, and cmd_ready 0.
REQ-031 n_rst asserted mid-operation SHALL immediately force the reset values above, independent of clk.

Verification (TICK_DIV=4, SPEED_MAX=100, RAMP_STEP=30)
REQ-032 FWD, dur=3 -> both speeds 30,60,90,100 on successive ticks; RUN for 3 ticks; then 70,40,10,0; done one pulse; enables 0 after.
REQ-033 LEFT, dur=2 -> speed_left stays 0; speed_right ramps to 100; both enables 1 until return to IDLE.
REQ-034 STOP or dur=0 -> busy never 1, done pulses 1 cycle later, speeds stay 0.
REQ-035 abort pulsed during RUN at speed 100 -> next cycle speeds 0, IDLE, no done; cmd_ready stays 0 while abort is held.
REQ-036 cmd_valid held during RAMP_UP with a second command -> ignored; accepted only after done, in IDLE.
REQ-037 n_rst low during RAMP_DOWN -> all outputs go to reset values asynchronously; after release, a new FWD command completes normally.
